// File: rtl/fetch_stage_stallable.sv
// Instruction fetch stage: PC register, next-PC select, single-outstanding
// req/grant/response handshake with instruction memory, a one-entry skid
// buffer for responses that arrive while decode is stalled, and the IF/ID
// pipeline register with valid, stall and flush.
//
// state | meaning
// REQ   | request presented at PC, waiting for grant
// WAIT  | request granted, waiting for response (kill_q drops it)
// HOLD  | response parked in skid buffer until decode stops stalling

module fetch_stage_stallable #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [ADDR_W-1:0]  PC_INC   = ADDR_W'(4)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         redirect_sel,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic [ADDR_W-1:0]  jr_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] Instruction_out,
    output logic [ADDR_W-1:0]  PCAddResult_out,
    output logic               valid_out,
    output logic [ADDR_W-1:0]  debug_PCR
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               kill_q, kill_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pcadd_q, pcadd_d;
    logic               valid_q, valid_d;

    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  req_pc_inc;

    assign redirect   = (redirect_sel != 2'b00);
    assign req_pc_inc = req_pc_q + PC_INC;

    // Redirect target select; targets are taken exactly as given (no alignment)
    always_comb begin
        case (redirect_sel)
            2'b01:   target = branch_target;
            2'b10:   target = jump_target;
            2'b11:   target = jr_target;
            default: target = pc_q;
        endcase
    end

    // Next-state: handshake FSM, PC update, skid buffer and IF/ID register
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        kill_d   = kill_q;
        skid_d   = skid_q;
        instr_d  = instr_q;
        pcadd_d  = pcadd_q;
        valid_d  = valid_q;

        case (state_q)
            S_REQ: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                    // A redirect in the grant cycle makes this fetch stale
                    kill_d   = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                    if (!kill_q && !redirect) begin
                        pc_d = req_pc_inc;
                        if (stall && valid_q && !flush) begin
                            skid_d  = imem_rdata;
                            state_d = S_HOLD;
                        end else if (!flush) begin
                            instr_d = imem_rdata;
                            pcadd_d = req_pc_inc;
                            valid_d = 1'b1;
                        end
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || flush) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    instr_d = skid_q;
                    pcadd_d = req_pc_inc;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides any sequential PC advance
        if (redirect) begin
            pc_d = target;
        end
        // Flush squashes IF/ID even over a same-cycle load or stall
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            kill_q   <= 1'b0;
            skid_q   <= '0;
            instr_q  <= '0;
            pcadd_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
            skid_q   <= skid_d;
            instr_q  <= instr_d;
            pcadd_q  <= pcadd_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req        = Reset && (state_q == S_REQ);
    assign imem_addr       = pc_q;
    assign Instruction_out = instr_q;
    assign PCAddResult_out = pcadd_q;
    assign valid_out       = valid_q;
    assign debug_PCR       = pc_q;

endmodule

// File: tb/tb_fetch_stage_stallable.sv
// Self-checking bench for fetch_stage_stallable. Main instance is driven
// cycle by cycle; a second instance with RESET_PC at the top of the address
// space runs against a free-running 1-cycle memory to check PC wrap.

module tb_fetch_stage_stallable;

    logic        Clk;
    logic        Reset;
    logic        stall, flush;
    logic [1:0]  redirect_sel;
    logic [31:0] branch_target, jump_target, jr_target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] Instruction_out, PCAddResult_out, debug_PCR;
    logic        valid_out;

    logic        imem_req2, imem_gnt2, imem_rvalid2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic [31:0] Instruction_out2, PCAddResult_out2, debug_PCR2;
    logic        valid_out2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb_q[$];

    fetch_stage_stallable dut (
        .Clk(Clk), .Reset(Reset), .stall(stall), .flush(flush),
        .redirect_sel(redirect_sel), .branch_target(branch_target),
        .jump_target(jump_target), .jr_target(jr_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instruction_out(Instruction_out), .PCAddResult_out(PCAddResult_out),
        .valid_out(valid_out), .debug_PCR(debug_PCR)
    );

    fetch_stage_stallable #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk(Clk), .Reset(Reset), .stall(1'b0), .flush(1'b0),
        .redirect_sel(2'b00), .branch_target(32'h0),
        .jump_target(32'h0), .jr_target(32'h0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .Instruction_out(Instruction_out2), .PCAddResult_out(PCAddResult_out2),
        .valid_out(valid_out2), .debug_PCR(debug_PCR2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h2008_0001;
        else if (a == 32'h4) return 32'h2009_0002;
        else                 return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One fetch with 1-cycle memory; load=1 means decode should receive it
    task automatic fetch(input logic [31:0] a, input bit load);
        chk("imem_req", {63'd0, imem_req}, 64'd1);
        chk("imem_addr", {32'd0, imem_addr}, {32'd0, a});
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("req_low_in_wait", {63'd0, imem_req}, 64'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = word(a);
        if (load) sb_q.push_back({word(a), a + 32'd4});
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    // Scoreboard monitor: every new IF/ID content must match the oldest expectation
    logic        prev_valid;
    logic [63:0] prev_out;
    initial begin
        prev_valid = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge Clk);
            if (Reset === 1'b1 && valid_out === 1'b1 &&
                (prev_valid !== 1'b1 || {Instruction_out, PCAddResult_out} !== prev_out)) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_load", 64'(sb_q.size()), 64'd1);
                end else begin
                    chk("sb_ifid", {Instruction_out, PCAddResult_out}, sb_q.pop_front());
                end
            end
            prev_valid = valid_out;
            prev_out   = {Instruction_out, PCAddResult_out};
        end
    end

    // Free-running 1-cycle memory for the wrap instance
    logic        pend2;
    logic [31:0] addr2;
    initial begin
        imem_gnt2    = 1'b1;
        imem_rvalid2 = 1'b0;
        imem_rdata2  = 32'h0;
        pend2        = 1'b0;
        addr2        = 32'h0;
        forever begin
            @(negedge Clk);
            imem_rvalid2 = pend2;
            imem_rdata2  = ~addr2;
            pend2        = (imem_req2 === 1'b1);
            if (pend2) addr2 = imem_addr2;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_sel = 2'b00;
        branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset state
        repeat (3) step();
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_instr", {32'd0, Instruction_out}, 64'd0);
        chk("rst_pcadd", {32'd0, PCAddResult_out}, 64'd0);
        chk("rst_pcr", {32'd0, debug_PCR}, 64'd0);
        Reset = 1'b1;
        #0;
        chk("rel_req", {63'd0, imem_req}, 64'd1);
        chk("rel_addr", {32'd0, imem_addr}, 64'd0);
        chk("wrap_rel_addr", {32'd0, imem_addr2}, 64'hFFFF_FFFC);
        step();
        chk("no_gnt_stay_req", {63'd0, imem_req}, 64'd1);
        chk("no_gnt_valid", {63'd0, valid_out}, 64'd0);

        // Sequential fetch, 1-cycle memory
        fetch(32'h0, 1'b1);
        chk("wrap_pcadd", {32'd0, PCAddResult_out2}, 64'd0);
        chk("wrap_instr", {32'd0, Instruction_out2}, 64'h0000_0003);
        chk("wrap_valid", {63'd0, valid_out2}, 64'd1);
        chk("wrap_next_addr", {32'd0, imem_addr2}, 64'd0);
        chk("pcadd_4", {32'd0, PCAddResult_out}, 64'd4);
        fetch(32'h4, 1'b1);
        chk("pcadd_8", {32'd0, PCAddResult_out}, 64'd8);
        chk("pcr_8", {32'd0, debug_PCR}, 64'd8);

        // Response arrives under stall -> HOLD, IF/ID held
        stall = 1'b1;
        fetch(32'h8, 1'b0);
        repeat (2) begin
            chk("hold_req", {63'd0, imem_req}, 64'd0);
            chk("hold_instr", {32'd0, Instruction_out}, {32'd0, word(32'h4)});
            chk("hold_pcadd", {32'd0, PCAddResult_out}, 64'd8);
            step();
        end
        chk("hold_pcr", {32'd0, debug_PCR}, 64'hC);
        sb_q.push_back({word(32'h8), 32'hC});
        stall = 1'b0;
        step();
        chk("skid_instr", {32'd0, Instruction_out}, {32'd0, word(32'h8)});
        chk("skid_pcadd", {32'd0, PCAddResult_out}, 64'hC);
        chk("skid_req", {63'd0, imem_req}, 64'd1);

        // Jump redirect while waiting; late response must be discarded
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect_sel = 2'b10; jump_target = 32'h400;
        step();
        redirect_sel = 2'b00;
        chk("jmp_pcr", {32'd0, debug_PCR}, 64'h400);
        chk("jmp_wait_req", {63'd0, imem_req}, 64'd0);
        imem_rvalid = 1'b1; imem_rdata = word(32'hC);
        step();
        imem_rvalid = 1'b0;
        chk("kill_pcadd", {32'd0, PCAddResult_out}, 64'hC);
        fetch(32'h400, 1'b1);
        chk("jmp_pcadd", {32'd0, PCAddResult_out}, 64'h404);

        // Stale response in REQ ignored
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("stale_addr", {32'd0, imem_addr}, 64'h404);
        chk("stale_pcadd", {32'd0, PCAddResult_out}, 64'h404);

        // Flush beats stall, PC unchanged
        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        chk("flush_valid", {63'd0, valid_out}, 64'd0);
        chk("flush_pcr", {32'd0, debug_PCR}, 64'h404);
        fetch(32'h404, 1'b1);
        chk("post_flush_valid", {63'd0, valid_out}, 64'd1);

        // Branch redirect in the grant cycle kills the fetch
        redirect_sel = 2'b01; branch_target = 32'h100; imem_gnt = 1'b1;
        step();
        redirect_sel = 2'b00; imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = word(32'h408);
        step();
        imem_rvalid = 1'b0;
        chk("br_addr", {32'd0, imem_addr}, 64'h100);
        chk("br_pcadd", {32'd0, PCAddResult_out}, 64'h408);

        // jr redirect in HOLD drops the skid entry (unaligned target)
        stall = 1'b1;
        fetch(32'h100, 1'b0);
        redirect_sel = 2'b11; jr_target = 32'h203;
        step();
        redirect_sel = 2'b00;
        chk("jr_addr", {32'd0, imem_addr}, 64'h203);
        chk("jr_req", {63'd0, imem_req}, 64'd1);
        stall = 1'b0;
        step();
        chk("jr_skid_dropped", {32'd0, PCAddResult_out}, 64'h408);
        fetch(32'h203, 1'b1);
        chk("jr_pcadd", {32'd0, PCAddResult_out}, 64'h207);

        step();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
